// File: rtl/extend_pipe.sv
// extend_pipe: two-stage pipelined immediate extender with valid/ready on both sides.
// Stage A latches mode/immediate, stage B latches the extended result.
// Optional EXTEND_STATS_EN adds beat_count / err_count statistics outputs.
module extend_pipe #(
  parameter int unsigned IMM_W = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ExtMode,
  input  logic [IMM_W-1:0] immediate,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] Extendout,
  output logic             mode_err,
  output logic             busy
`ifdef EXTEND_STATS_EN
  ,
  output logic [15:0]      beat_count,
  output logic [7:0]       err_count
`endif
);

  localparam int unsigned PAD_W = OUT_W - IMM_W;

  localparam logic [2:0] MODE_ZERO  = 3'd0;
  localparam logic [2:0] MODE_SIGN  = 3'd1;
  localparam logic [2:0] MODE_UPPER = 3'd2;
  localparam logic [2:0] MODE_BOFF  = 3'd3;

  logic             a_valid;
  logic [2:0]       a_mode;
  logic [IMM_W-1:0] a_imm;
  logic             b_valid;
  logic [OUT_W-1:0] b_data;
  logic             b_err;

  logic             b_load;
  logic             accept;
  logic             retire;
  logic [OUT_W-1:0] sext_c;
  logic [OUT_W-1:0] ext_c;
  logic             err_c;

  // Handshake control: B drains to the consumer, A refills whenever B can take it.
  assign b_load    = a_valid && (!b_valid || out_ready);
  assign in_ready  = !a_valid || b_load;
  assign accept    = in_valid && in_ready;
  assign retire    = b_valid && out_ready;
  assign out_valid = b_valid;
  assign Extendout = b_data;
  assign mode_err  = b_err;
  assign busy      = a_valid || b_valid;

  // Extension arithmetic on the stage-A immediate; illegal modes yield zero plus an error flag.
  always_comb begin
    sext_c = {{PAD_W{a_imm[IMM_W-1]}}, a_imm};
    ext_c  = '0;
    err_c  = 1'b0;
    case (a_mode)
      MODE_ZERO:  ext_c = {{PAD_W{1'b0}}, a_imm};
      MODE_SIGN:  ext_c = sext_c;
      MODE_UPPER: ext_c = {a_imm, {PAD_W{1'b0}}};
      MODE_BOFF:  ext_c = {sext_c[OUT_W-3:0], 2'b00};
      default: begin
        ext_c = '0;
        err_c = 1'b1;
      end
    endcase
  end

  // Stage A / stage B registers; reset discards anything in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_valid <= 1'b0;
      a_mode  <= '0;
      a_imm   <= '0;
      b_valid <= 1'b0;
      b_data  <= '0;
      b_err   <= 1'b0;
    end else begin
      if (accept) begin
        a_valid <= 1'b1;
        a_mode  <= ExtMode;
        a_imm   <= immediate;
      end else if (b_load) begin
        a_valid <= 1'b0;
      end
      if (b_load) begin
        b_valid <= 1'b1;
        b_data  <= ext_c;
        b_err   <= err_c;
      end else if (retire) begin
        b_valid <= 1'b0;
      end
    end
  end

`ifdef EXTEND_STATS_EN
  // Retired-beat counter (wrapping) and error-beat counter (saturating).
  always_ff @(posedge CLK) begin
    if (RST) begin
      beat_count <= '0;
      err_count  <= '0;
    end else if (retire) begin
      beat_count <= beat_count + 16'd1;
      if (b_err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
`endif

endmodule
